// File: rtl/comp_pipe_if.sv
// Operand/result handshake bundle for comp_pipe, plus the counter clear and readback.
interface comp_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             y_lt;
  logic             y_eq;
  logic             y_gt;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_lt;
  logic [CNT_W-1:0] cnt_eq;
  logic [CNT_W-1:0] cnt_gt;

  // Comparator side
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready, clr_cnt,
    output in_ready, out_valid, y_lt, y_eq, y_gt, cnt_lt, cnt_eq, cnt_gt
  );

  // Source/consumer side
  modport master (
    output in_valid, a, b, signed_mode, out_ready, clr_cnt,
    input  in_ready, out_valid, y_lt, y_eq, y_gt, cnt_lt, cnt_eq, cnt_gt
  );
endinterface

// File: rtl/comp_pipe.sv
// Two-stage pipelined magnitude comparator (unsigned or signed per transaction)
// with valid/ready flow control and saturating per-outcome delivery counters.
module comp_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  comp_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_s2_valid;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;
  logic [CNT_W-1:0] r_cnt_lt;
  logic [CNT_W-1:0] r_cnt_eq;
  logic [CNT_W-1:0] r_cnt_gt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_a_key;
  logic [WIDTH-1:0] w_b_key;

  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  // Handshake outputs are forced low during reset so nothing is accepted or
  // delivered (and no counter moves) in a reset cycle.
  assign bus.in_ready  = w_s1_adv && !rst;
  assign bus.out_valid = r_s2_valid && !rst;
  assign w_out_xfer    = bus.out_valid && bus.out_ready;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign w_a_key = r_a ^ {r_mode, {(WIDTH-1){1'b0}}};
  assign w_b_key = r_b ^ {r_mode, {(WIDTH-1){1'b0}}};

  // Stage 1: capture operands and mode on an input transfer; hold when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_mode <= bus.signed_mode;
      end
    end
  end

  // Stage 2: register one-hot flags; a bubble only clears valid, flags keep last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_lt       <= 1'b0;
      r_eq       <= 1'b0;
      r_gt       <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_lt <= (w_a_key <  w_b_key);
        r_eq <= (w_a_key == w_b_key);
        r_gt <= (w_a_key >  w_b_key);
      end
    end
  end

  // Outcome counters: bump on delivered results, saturate, clear has priority.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      r_cnt_lt <= '0;
      r_cnt_eq <= '0;
      r_cnt_gt <= '0;
    end else if (w_out_xfer) begin
      if (r_lt && r_cnt_lt != CNT_MAX) r_cnt_lt <= r_cnt_lt + CNT_ONE;
      if (r_eq && r_cnt_eq != CNT_MAX) r_cnt_eq <= r_cnt_eq + CNT_ONE;
      if (r_gt && r_cnt_gt != CNT_MAX) r_cnt_gt <= r_cnt_gt + CNT_ONE;
    end
  end

  assign bus.y_lt   = r_lt;
  assign bus.y_eq   = r_eq;
  assign bus.y_gt   = r_gt;
  assign bus.cnt_lt = r_cnt_lt;
  assign bus.cnt_eq = r_cnt_eq;
  assign bus.cnt_gt = r_cnt_gt;

endmodule

// File: tb/tb_comp_pipe.sv
// Scoreboard bench for comp_pipe: directed pairs push expected flags, a monitor
// pops and compares on every delivered result. A second CNT_W=4 instance
// exercises counter saturation.
module tb_comp_pipe;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_pipe_if #(.WIDTH(8), .CNT_W(16)) bus  ();
  comp_pipe_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  comp_pipe #(.WIDTH(8), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  comp_pipe #(.WIDTH(8), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every delivered result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {29'd0, bus.y_lt, bus.y_eq, bus.y_gt}, 32'd0);
      end else begin
        chk("result_flags", {29'd0, bus.y_lt, bus.y_eq, bus.y_gt}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // Present one pair; push its expectation once acceptance at the next edge is certain.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic m, input logic [2:0] e);
    int n = 0;
    bus.in_valid = 1'b1; bus.a = ta; bus.b = tb_v; bus.signed_mode = m;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.signed_mode = 0;
    bus.out_ready = 1; bus.clr_cnt = 0;
    bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.signed_mode = 0;
    bus4.out_ready = 1; bus4.clr_cnt = 0;

    // Reset state
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_flags", {29'd0, bus.y_lt, bus.y_eq, bus.y_gt}, 32'd0);
    chk("rst_cnt_lt", {16'd0, bus.cnt_lt}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: basic unsigned, latency 2
    send(8'd5, 8'd9, 1'b0, LT);
    chk("lat_not_early", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    send(8'd9, 8'd9, 1'b0, EQ);
    send(8'd200, 8'd3, 1'b0, GT);
    idle(4);
    chk("t1_cnt_lt", {16'd0, bus.cnt_lt}, 32'd1);
    chk("t1_cnt_eq", {16'd0, bus.cnt_eq}, 32'd1);
    chk("t1_cnt_gt", {16'd0, bus.cnt_gt}, 32'd1);

    // 2: same bits, mode differs back-to-back
    send(8'h80, 8'h01, 1'b1, LT);
    send(8'h80, 8'h01, 1'b0, GT);
    idle(4);
    chk("t2_cnt_lt", {16'd0, bus.cnt_lt}, 32'd2);
    chk("t2_cnt_gt", {16'd0, bus.cnt_gt}, 32'd2);

    // 3: backpressure, 2 accepted then stall with stable flags
    bus.out_ready = 1'b0;
    send(8'd1, 8'd2, 1'b0, LT);
    send(8'd7, 8'd7, 1'b0, EQ);
    fork
      begin
        send(8'hFF, 8'h00, 1'b1, LT);
        send(8'h7F, 8'h80, 1'b1, GT);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
          chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("bp_flags_hold", {29'd0, bus.y_lt, bus.y_eq, bus.y_gt}, {29'd0, LT});
          chk("bp_cnt_hold", {16'd0, bus.cnt_lt}, 32'd2);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(5);
    chk("t3_cnt_lt", {16'd0, bus.cnt_lt}, 32'd4);
    chk("t3_cnt_eq", {16'd0, bus.cnt_eq}, 32'd2);
    chk("t3_cnt_gt", {16'd0, bus.cnt_gt}, 32'd3);
    chk("t3_drained", exp_q.size(), 32'd0);

    // 4: saturation on the CNT_W=4 instance, 20 gt pairs at full rate
    bus4.a = 8'd200; bus4.b = 8'd10; bus4.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1; bus4.in_valid = 1'b0;
    idle(4);
    chk("t4_cnt_gt_sat", {28'd0, bus4.cnt_gt}, 32'd15);
    chk("t4_cnt_lt", {28'd0, bus4.cnt_lt}, 32'd0);
    chk("t4_cnt_eq", {28'd0, bus4.cnt_eq}, 32'd0);

    // 5: clear coinciding with an eq delivery while cnt_eq=3
    send(8'd4, 8'd4, 1'b0, EQ);
    idle(4);
    send(8'h55, 8'h55, 1'b1, EQ);
    @(posedge clk); #1;
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    chk("t5_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t5_pre_cnt_eq", {16'd0, bus.cnt_eq}, 32'd3);
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    chk("t5_cnt_eq", {16'd0, bus.cnt_eq}, 32'd0);
    chk("t5_cnt_lt", {16'd0, bus.cnt_lt}, 32'd0);
    chk("t5_cnt_gt", {16'd0, bus.cnt_gt}, 32'd0);

    // 6: reset with two in flight under backpressure
    send(8'd1, 8'd200, 1'b1, GT);
    idle(4);
    chk("t6_pre_cnt_gt", {16'd0, bus.cnt_gt}, 32'd1);
    bus.out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b0, LT);
    send(8'd3, 8'd2, 1'b0, GT);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_cnt_gt", {16'd0, bus.cnt_gt}, 32'd0);
    chk("t6_cnt_lt", {16'd0, bus.cnt_lt}, 32'd0);
    bus.out_ready = 1'b1;
    send(8'd3, 8'd250, 1'b1, GT);
    @(posedge clk); #1;
    chk("t6_post_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t6_post_gt", {31'd0, bus.y_gt}, 32'd1);
    idle(3);
    chk("t6_post_cnt_gt", {16'd0, bus.cnt_gt}, 32'd1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    chk("final_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/comp_pipe.md
Name: comp_pipe

Overview:
Parametrised, pipelined magnitude comparator. It is the registered successor of the combinational a/b comparator.
- Accepts operand pairs over a valid/ready handshake.
- Compares them as unsigned or two's-complement signed, selected per transaction.
- Returns one-hot less/equal/greater flags two cycles later.
- Keeps saturating per-outcome event counters for scoreboarding and debug.
- Sits between a stimulus/operand source and any downstream consumer that may apply backpressure.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CNT_W, 16, width of each outcome counter (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operand pair
a  in  WIDTH  operand A
b  in  WIDTH  operand B
signed_mode  in  1  1 = compare as two's complement, 0 = unsigned; sampled with a/b
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y_lt  out  1  A < B
y_eq  out  1  A == B
y_gt  out  1  A > B
clr_cnt  in  1  synchronous clear of all counters
cnt_lt  out  CNT_W  number of delivered lt results, saturating
cnt_eq  out  CNT_W  number of delivered eq results, saturating
cnt_gt  out  CNT_W  number of delivered gt results, saturating

Behaviour:
Clock/reset:
- Single clock domain on clk.
- rst is synchronous, active-high; the design has no asynchronous reset.
- State after any cycle with rst=1: s1_valid=0, s2_valid=0, y_lt/y_eq/y_gt=0, all counters=0.
- in_ready=0 while rst=1; out_valid=0 while rst=1.

Pipeline (two stages, latency 2 cycles with no backpressure):
- Stage 1 registers a, b, signed_mode and s1_valid.
- Stage 2 registers the computed flags and s2_valid.
- out_valid = s2_valid; the flag outputs are the stage-2 registers.
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv (combinational path from out_ready is permitted).
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Full throughput: with out_ready held at 1, one result per cycle.
- Under backpressure, stage-2 contents and flags hold stable until transferred. Stage 1 also holds when stage 2 cannot advance. No transaction is dropped or duplicated.
- A bubble (s1_valid=0) advancing into stage 2 clears s2_valid; the flags then hold their last values, and consumers must qualify them with out_valid.

Compare rules:
- signed_mode=0: plain unsigned magnitude compare.
- signed_mode=1: compare with sign-bit inversion, i.e. MSB=1 is negative.
- Whenever s2_valid=1, exactly one of y_lt/y_eq/y_gt is 1.
- Mode is per transaction; back-to-back pairs with different modes must each use their own mode.

Counters:
- On each output transfer, the counter matching the delivered flag increments by 1.
- Each counter saturates at 2^CNT_W-1 and never wraps.
- clr_cnt=1 sets all counters to 0 on the next edge. If clr_cnt coincides with an output transfer, clear wins and the counters end at 0.
- Counters do not change on non-transfer cycles, including while out_valid=1 and out_ready=0.

Reset mid-operation:
- Any in-flight transactions are discarded.
- No counter updates occur in the reset cycle.
- The first transfer after rst deasserts is accepted normally.

Test Plan:
1. WIDTH=8. Pairs (5,9,u), (9,9,u), (200,3,u) with out_ready=1 -> results 2 cycles after each input, flags lt, eq, gt in order; cnt_lt=cnt_eq=cnt_gt=1.
2. Pair (0x80,0x01) sent once with signed_mode=1 and once with signed_mode=0, back-to-back -> first result lt, second result gt; per-transaction mode is honoured.
3. Send 4 pairs while out_ready=0 -> in_ready drops after 2 are accepted, out_valid=1 with flags stable. Release out_ready -> all 4 results delivered in order, no loss or duplication, counters total 4.
4. CNT_W=4, 20 pairs with a>b, out_ready=1 -> cnt_gt increments to 15 and stays at 15; cnt_lt=cnt_eq=0.
5. Assert clr_cnt in the same cycle as an eq output transfer with cnt_eq=3 -> cnt_eq=0 next cycle, and all other counters are also 0.
6. Pulse rst with 2 transactions in flight and out_ready=0 -> out_valid=0, counters 0 on the next cycle; the next pair after reset returns its correct flag after 2 cycles.
